// File: rtl/bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_addsub
// Purpose  : Digit-serial packed-BCD adder/subtractor, one digit per clock,
//            LSD first, with start/busy/done handshake and invalid-digit flag.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_addsub #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  err
);

  localparam int c_w = 4 * DIGITS;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [c_w-1:0]   r_a;
  logic [c_w-1:0]   r_b;
  logic             r_sub;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [c_w-1:0]   r_result;
  logic             r_cout;
  logic             r_err;
  logic             r_busy;
  logic             r_done;

  logic [3:0]       w_bd;
  logic [4:0]       w_t;
  logic             w_gt9;
  logic [3:0]       w_digit;
  logic [c_w-1:0]   w_res_ins;
  logic             w_err_in;
  logic             w_last;

  // Operands shift right each RUN cycle, so the current digit is always [3:0].
  assign w_bd    = r_sub ? (4'd9 - r_b[3:0]) : r_b[3:0];
  assign w_t     = {1'b0, r_a[3:0]} + {1'b0, w_bd} + {4'b0, r_carry};
  assign w_gt9   = (w_t > 5'd9);
  assign w_digit = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
  assign w_last  = (r_cnt == c_last);

  generate
    if (DIGITS == 1) begin : g_one_digit
      assign w_res_ins = w_digit;
    end else begin : g_multi_digit
      assign w_res_ins = {w_digit, r_result[c_w-1:4]};
    end
  endgenerate

  always_comb begin
    w_err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) w_err_in = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_sub    <= sub;
            r_carry  <= sub ? ~cin : cin;
            r_result <= '0;
            r_cnt    <= '0;
            r_err    <= w_err_in;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_gt9;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // An invalid input digit makes the whole result meaningless: zero it.
            r_result <= r_err ? '0 : w_res_ins;
            r_cout   <= r_err ? 1'b0 : w_gt9;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_result <= w_res_ins;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_addsub
// Purpose  : Directed self-checking bench for bcd_serial_addsub (DIGITS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        err;

  int n_pass;
  int n_total;

  bcd_serial_addsub #(.DIGITS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents operands with a one-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic launch(input logic [15:0] va, input logic [15:0] vb,
                        input logic vsub, input logic vcin);
    @(negedge clk);
    a = va; b = vb; sub = vsub; cin = vcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then checks latency, busy duration and outputs.
  task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] er,
                           input logic ec, input logic ee);
    int  lat;
    int  busy_n;
    bit  seen;
    lat = 0; busy_n = 0; seen = 1'b0;
    if (busy) busy_n++;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"},   32'(lat), 32'(exp_lat));
    check({tag, ".busy_cyc"},  32'(busy_n), 32'(exp_lat));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".result"},    32'(result), 32'(er));
    check({tag, ".cout"},      32'(cout), 32'(ec));
    check({tag, ".err"},       32'(err), 32'(ee));
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy",   32'(busy),   32'd0);
    check("reset.done",   32'(done),   32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.cout",   32'(cout),   32'd0);
    check("reset.err",    32'(err),    32'd0);
    rst_n = 1'b1;

    launch(16'h1234, 16'h5678, 1'b0, 1'b0);
    check("add1.busy_start", 32'(busy), 32'd1);
    wait_done("add1", 4, 16'h6912, 1'b0, 1'b0);
    @(negedge clk);
    check("add1.done_pulse", 32'(done), 32'd0);
    check("add1.hold",       32'(result), 32'h6912);

    launch(16'h9999, 16'h0001, 1'b0, 1'b0);
    wait_done("add2", 4, 16'h0000, 1'b1, 1'b0);
    launch(16'h0000, 16'h0000, 1'b0, 1'b1);
    wait_done("add3", 4, 16'h0001, 1'b0, 1'b0);

    launch(16'h5000, 16'h1234, 1'b1, 1'b0);
    wait_done("sub1", 4, 16'h3766, 1'b1, 1'b0);
    launch(16'h1234, 16'h5000, 1'b1, 1'b0);
    wait_done("sub2", 4, 16'h6234, 1'b0, 1'b0);
    launch(16'h1000, 16'h0999, 1'b1, 1'b1);
    wait_done("sub3", 4, 16'h0000, 1'b1, 1'b0);

    launch(16'h12A4, 16'h0001, 1'b0, 1'b0);
    wait_done("inval", 4, 16'h0000, 1'b0, 1'b1);

    // Start re-asserted mid-RUN with different operands must be ignored.
    launch(16'h1234, 16'h5678, 1'b0, 1'b0);
    a = 16'h9999; b = 16'h9999; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 3, 16'h6912, 1'b0, 1'b0);

    // Back-to-back: start while done is high.
    a = 16'h5000; b = 16'h1234; sub = 1'b1; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b.busy_start", 32'(busy), 32'd1);
    wait_done("b2b", 4, 16'h3766, 1'b1, 1'b0);

    // Asynchronous reset in the middle of RUN.
    launch(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.busy",   32'(busy),   32'd0);
    check("abort.done",   32'(done),   32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.cout",   32'(cout),   32'd0);
    check("abort.err",    32'(err),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int done_cnt;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      check("abort.no_done", 32'(done_cnt), 32'd0);
    end
    launch(16'h0789, 16'h0456, 1'b0, 1'b0);
    wait_done("post_rst", 4, 16'h1245, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
